// File: rtl/bp_be_pkg.sv
// Shared backend constants and the stage-entry struct macro for the pipe tracker.
`ifndef BP_BE_PKG_SV
`define BP_BE_PKG_SV

package bp_be_pkg;
  localparam int bp_be_itag_width_gp     = 8;
  localparam int bp_be_pipe_stage_els_gp = 5;
endpackage

// Declares bp_be_stage_entry_s {v, itag} for a given itag width inside the using scope.
`define BP_BE_DECLARE_STAGE_ENTRY_S(itag_width_mp) \
  typedef struct packed { \
    logic                     v; \
    logic [itag_width_mp-1:0] itag; \
  } bp_be_stage_entry_s;

`endif

// File: rtl/bp_be_itag_gen.sv
// Itag allocator: wrapping next-itag counter, with dense rewind on flush when
// BP_BE_ITAG_ROLLBACK_EN is defined.
module bp_be_itag_gen
  import bp_be_pkg::*;
#(
  parameter int itag_width_p = bp_be_itag_width_gp
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    issue_i,
  input  logic                    flush_i,
  input  logic                    stall_i,
  input  logic                    last_v_i,
  input  logic [itag_width_p-1:0] last_itag_i,
  input  logic                    commit_v_i,
  input  logic [itag_width_p-1:0] commit_itag_i,
  output logic [itag_width_p-1:0] next_itag_o
);

  logic [itag_width_p-1:0] r_next_itag;
  assign next_itag_o = r_next_itag;

`ifdef BP_BE_ITAG_ROLLBACK_EN
  logic [itag_width_p-1:0] r_last_commit;
  logic [itag_width_p-1:0] w_rewind_base;

  // Youngest surviving itag: a stalled final-stage entry, else the newest retirement.
  assign w_rewind_base = (last_v_i & stall_i) ? last_itag_i
                       : (commit_v_i ? commit_itag_i : r_last_commit);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_next_itag   <= '0;
      r_last_commit <= '1;
    end else begin
      if (commit_v_i) r_last_commit <= commit_itag_i;
      if (flush_i)      r_next_itag <= w_rewind_base + itag_width_p'(1);
      else if (issue_i) r_next_itag <= r_next_itag + itag_width_p'(1);
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{flush_i, stall_i, last_v_i, last_itag_i, commit_v_i, commit_itag_i};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)      r_next_itag <= '0;
    else if (issue_i) r_next_itag <= r_next_itag + itag_width_p'(1);
  end
`endif

endmodule

// File: rtl/bp_be_pipe_tracker.sv
// In-flight instruction tracker: tags issues, shifts {v, itag} down a fixed-depth pipe,
// commits from the final stage. Optional BP_BE_ITAG_ROLLBACK_EN keeps itags dense on flush.
module bp_be_pipe_tracker
  import bp_be_pkg::*;
#(
  parameter  int itag_width_p     = bp_be_itag_width_gp,
  parameter  int pipe_stage_els_p = bp_be_pipe_stage_els_gp,
  localparam int cnt_w_lp         = $clog2(pipe_stage_els_p+1)
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic                                     issue_v_i,
  output logic                                     issue_ready_o,
  output logic [itag_width_p-1:0]                  issue_itag_o,
  input  logic                                     stall_i,
  input  logic                                     flush_i,
  output logic [pipe_stage_els_p-1:0]              stage_v_o,
  output logic [pipe_stage_els_p*itag_width_p-1:0] stage_itag_o,
  output logic                                     commit_v_o,
  output logic [itag_width_p-1:0]                  commit_itag_o,
  output logic [cnt_w_lp-1:0]                      inflight_o
);

  `BP_BE_DECLARE_STAGE_ENTRY_S(itag_width_p)

  localparam int last_lp = pipe_stage_els_p - 1;

  bp_be_stage_entry_s      r_stage [pipe_stage_els_p];
  logic                    w_issue_acc;
  logic [itag_width_p-1:0] w_next_itag;
  logic [cnt_w_lp-1:0]     w_inflight;

  assign issue_ready_o = ~stall_i & ~flush_i;
  assign w_issue_acc   = issue_v_i & issue_ready_o;
  assign issue_itag_o  = w_next_itag;
  assign commit_v_o    = r_stage[last_lp].v & ~stall_i;
  assign commit_itag_o = r_stage[last_lp].itag;

  bp_be_itag_gen #(.itag_width_p(itag_width_p)) u_itag_gen (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .issue_i      (w_issue_acc),
    .flush_i      (flush_i),
    .stall_i      (stall_i),
    .last_v_i     (r_stage[last_lp].v),
    .last_itag_i  (r_stage[last_lp].itag),
    .commit_v_i   (commit_v_o),
    .commit_itag_i(commit_itag_o),
    .next_itag_o  (w_next_itag)
  );

  // Unstalled flush: the entry sliding into the final stage came from a killed stage.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < pipe_stage_els_p; k++) r_stage[k] <= '0;
    end else if (!stall_i) begin
      r_stage[0] <= {w_issue_acc, w_next_itag};
      for (int k = 1; k < pipe_stage_els_p; k++)
        r_stage[k] <= {r_stage[k-1].v & ~flush_i, r_stage[k-1].itag};
    end else if (flush_i) begin
      for (int k = 0; k < last_lp; k++) r_stage[k].v <= 1'b0;
    end
  end

  genvar g;
  generate
    for (g = 0; g < pipe_stage_els_p; g++) begin : g_out
      assign stage_v_o[g]                                  = r_stage[g].v;
      assign stage_itag_o[g*itag_width_p +: itag_width_p] = r_stage[g].itag;
    end
  endgenerate

  always_comb begin
    w_inflight = '0;
    for (int k = 0; k < pipe_stage_els_p; k++)
      w_inflight = w_inflight + cnt_w_lp'(r_stage[k].v);
  end
  assign inflight_o = w_inflight;

endmodule

// File: tb/tb_bp_be_pipe_tracker.sv
// Randomised + directed bench: an age-based in-flight model predicts timing, a
// scoreboard queue of issued itags is popped by a separate monitor on each commit.
module tb_bp_be_pipe_tracker;
  localparam int W = 8;
  localparam int N = 5;
  localparam int CW = $clog2(N+1);

  logic           clk = 1'b0, rst = 1'b1, iv = 1'b0, st = 1'b0, fl = 1'b0;
  logic           issue_ready_o, commit_v_o;
  logic [W-1:0]   issue_itag_o, commit_itag_o;
  logic [N-1:0]   stage_v_o;
  logic [N*W-1:0] stage_itag_o;
  logic [CW-1:0]  inflight_o;

  bp_be_pipe_tracker #(.itag_width_p(W), .pipe_stage_els_p(N)) dut (
    .clk_i(clk), .reset_i(rst), .issue_v_i(iv), .issue_ready_o(issue_ready_o),
    .issue_itag_o(issue_itag_o), .stall_i(st), .flush_i(fl), .stage_v_o(stage_v_o),
    .stage_itag_o(stage_itag_o), .commit_v_o(commit_v_o), .commit_itag_o(commit_itag_o),
    .inflight_o(inflight_o)
  );

  always #5 clk = ~clk;

  typedef struct { int itag; int age; } ent_t;
  ent_t mq[$];    // in-flight instructions, oldest first; age = stage index
  int   sb_q[$];  // scoreboard: expected commit order
  int   nt, lc, total = 0, bad = 0;
  bit   m_acc, m_cm, m_held;
  int   m_front, m_rb;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: advance on clock edges, clear on reset.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mq.delete(); sb_q.delete(); nt = 0; lc = 255;
    end else begin
      m_acc   = iv && !st && !fl;
      m_cm    = mq.size() > 0 && mq[0].age == N-1 && !st;
      m_held  = mq.size() > 0 && mq[0].age == N-1 && st;
      m_front = mq.size() > 0 ? mq[0].itag : 0;
      m_rb    = (m_cm || m_held) ? m_front : lc;
      if (fl)
        while (mq.size() > 0 && mq[$].age < N-1) begin
          void'(mq.pop_back());
          if (sb_q.size() > 0) void'(sb_q.pop_back());
        end
      if (m_cm) begin lc = m_front; void'(mq.pop_front()); end
      if (!st) foreach (mq[i]) mq[i].age++;
`ifdef BP_BE_ITAG_ROLLBACK_EN
      if (fl) nt = (m_rb + 1) % 256;
`endif
      if (m_acc) begin
        mq.push_back('{itag: nt, age: 0});
        sb_q.push_back(nt);
        nt = (nt + 1) % 256;
      end
    end
  end

  // Monitor: sample mid-cycle after inputs have settled.
  initial forever begin
    logic [N-1:0] ev;
    @(negedge clk); #2;
    if (!rst) begin
      ev = '0;
      foreach (mq[i]) ev[mq[i].age] = 1'b1;
      chk("ready", issue_ready_o, !st && !fl);
      chk("inflight", inflight_o, mq.size());
      chk("stage_v", stage_v_o, ev);
      foreach (mq[i]) chk("stage_itag", stage_itag_o[mq[i].age*W +: W], mq[i].itag);
      chk("commit_v", commit_v_o, mq.size() > 0 && mq[0].age == N-1 && !st);
      if (iv && issue_ready_o) chk("issue_itag", issue_itag_o, nt);
      if (commit_v_o) begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL commit_order: got commit %0h with nothing expected", commit_itag_o);
        end else chk("commit_itag", commit_itag_o, sb_q.pop_front());
      end
    end
  end

  task automatic cyc(input bit v, input bit s, input bit f);
    @(negedge clk); #1;
    iv = v; st = s; fl = f;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    iv = 0; st = 0; fl = 0; rst = 1; #1;
    chk("rst_stage_v", stage_v_o, 0);
    chk("rst_stage_itag", stage_itag_o, 0);
    chk("rst_commit_v", commit_v_o, 0);
    chk("rst_inflight", inflight_o, 0);
    chk("rst_issue_itag", issue_itag_o, 0);
    chk("rst_ready", issue_ready_o, 1);
    @(negedge clk); #1;
    rst = 0;
  endtask

  initial begin
    do_reset();
    // single issue walks the pipe and commits after N cycles
    cyc(1, 0, 0); repeat (8) cyc(0, 0, 0);
    // sustained issue across itag wrap
    do_reset();
    repeat (260) cyc(1, 0, 0);
    repeat (7) cyc(0, 0, 0);
    // stall with a full pipe and a pending issue
    do_reset();
    repeat (5) cyc(1, 0, 0);
    repeat (3) cyc(1, 1, 0);
    repeat (8) cyc(0, 0, 0);
    // flush with a full pipe beats a simultaneous issue
    do_reset();
    repeat (5) cyc(1, 0, 0);
    cyc(1, 0, 1);
    cyc(1, 0, 0);
    repeat (7) cyc(0, 0, 0);
    // flush + stall with itag 7 held in the final stage
    do_reset();
    repeat (8) cyc(1, 0, 0);
    repeat (4) cyc(0, 0, 0);
    cyc(0, 1, 1);
    cyc(1, 0, 0);
    repeat (7) cyc(0, 0, 0);
    // async reset mid-stream
    repeat (3) cyc(1, 0, 0);
    do_reset();
    cyc(1, 0, 0); repeat (6) cyc(0, 0, 0);
    // random traffic
    repeat (800) cyc($urandom_range(3) != 0, $urandom_range(4) == 0, $urandom_range(11) == 0);
    repeat (8) cyc(0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
